// File: rtl/y_buffer.sv
// y_buffer: gathers four MAC lanes per strobe for DEPTH strobes, then streams
// the frame out one word per cycle under a valid/ready handshake.
module y_buffer #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_lane1,
    input  logic [DATA_W-1:0] res_lane2,
    input  logic [DATA_W-1:0] res_lane3,
    input  logic [DATA_W-1:0] res_lane4,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              collect_ready,
    output logic              send_done,
    output logic              overrun
);
    localparam int CW    = $clog2(DEPTH);
    localparam int OW    = CW + 2;
    localparam int WORDS = 4 * DEPTH;
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     ccnt_q, ccnt_d;
    logic [OW-1:0]     ocnt_q, ocnt_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] mem_q [WORDS];
    logic              capture, xfer;

    assign collect_ready = state_q == S_COLLECT;
    assign out_valid     = state_q == S_SEND;
    assign send_done     = state_q == S_DONE;
    assign out_last      = out_valid && ocnt_q == OW'(WORDS - 1);
    assign out_data      = out_valid ? mem_q[ocnt_q] : '0;
    assign overrun       = overrun_q;
    assign capture       = collect_ready && res_valid;
    assign xfer          = out_valid && out_ready;

    // Power-of-two sizes make both counters wrap to 0 exactly at frame end.
    always_comb begin
        ccnt_d    = capture ? ccnt_q + 1'b1 : ccnt_q;
        ocnt_d    = xfer ? ocnt_q + 1'b1 : ocnt_q;
        overrun_d = overrun_q || (res_valid && !collect_ready);
        state_d   = (capture && ccnt_q == CW'(DEPTH - 1)) ? S_SEND :
                    (xfer && out_last) ? S_DONE :
                    send_done ? S_COLLECT : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_COLLECT;
            ccnt_q    <= '0;
            ocnt_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ccnt_q    <= ccnt_d;
            ocnt_q    <= ocnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (capture) begin
            mem_q[{ccnt_q, 2'd0}] <= res_lane1;
            mem_q[{ccnt_q, 2'd1}] <= res_lane2;
            mem_q[{ccnt_q, 2'd2}] <= res_lane3;
            mem_q[{ccnt_q, 2'd3}] <= res_lane4;
        end
    end
endmodule
